uart_tx_fifo: RTL
=================

Name: uart_tx_fifo

Overview:
Buffered transmit front-end that sits between byte producers (command/response logic, the Enigma core output) and uart_tx. Producers push bytes into a circular FIFO at any rate. The block drains the FIFO one byte at a time by driving uart_tx's tx_byte/tx_start inputs and observing its tx_busy output. This gives the transmit path the same decoupling on the producer side that uart_rx gives on the consumer side.

Parameters:
DEPTH, 16, FIFO entries; power of two, 2..256
AW, 4, address width; must equal log2(DEPTH)

Ports:
clk  in  1  system clock (12 MHz)
rst_n  in  1  synchronous active-low reset
wr_data  in  8  byte to enqueue
wr_en  in  1  enqueue strobe, sampled on rising clk
flush  in  1  discard all queued bytes; does not abort the byte already handed to uart_tx
full  out  1  FIFO holds DEPTH bytes
empty  out  1  FIFO holds 0 bytes
level  out  AW+1  current occupancy, 0..DEPTH
overflow  out  1  sticky flag: a write was attempted while full; cleared only by reset or flush
tx_byte  out  8  to uart_tx tx_byte; held stable from the tx_start cycle until tx_busy falls
tx_start  out  1  to uart_tx tx_start; one-cycle pulse
tx_busy  in  1  from uart_tx
drain_active  out  1  high while the FSM is in any state other than IDLE

Behaviour:
- Reset is synchronous on rst_n=0 at a rising clk. Reset values:
  - full=0, empty=1, level=0, overflow=0
  - tx_byte=8'h00, tx_start=0, drain_active=0
  - read and write pointers = 0; FSM = IDLE
  - Reset mid-drain abandons the FSM immediately. uart_tx is reset by the same rst_n.
- FIFO storage: pointers are AW bits wide and wrap modulo DEPTH. level is a separate AW+1-bit counter.
- Write: if wr_en=1 and not full, store wr_data at wptr and increment wptr.
- Write while full: the data is dropped and overflow sets to 1 on the next cycle.
  - Exception: if a pop happens in the same cycle, the write is accepted and overflow does not set.
- Simultaneous push and pop in one cycle: level is unchanged and both pointers advance.
- All status outputs (full, empty, level) are registered and reflect the state after the current edge.
- FSM states:
  - IDLE: if not empty, latch mem[rptr] into tx_byte, increment rptr, decrement level (pop) -> START.
  - START: assert tx_start for exactly this cycle -> WAIT_BUSY.
  - WAIT_BUSY: on tx_busy=1 -> WAIT_DONE. If tx_busy is still 0 after 2 cycles in this state -> WAIT_DONE anyway (guard against a missed busy edge).
  - WAIT_DONE: on tx_busy=0 -> IDLE.
- Steady-state latency: wr_en into an empty FIFO with the FSM in IDLE gives tx_start high 2 cycles later. Cycle N is the write, N+1 is the pop, N+2 is the START state.
- Back-to-back: the next pop happens the first IDLE cycle after tx_busy falls. The inter-byte gap is about 2 clk, which is below one bit time.
- Flush:
  - Sets rptr=wptr, level=0, empty=1, overflow=0.
  - The byte already popped still completes, and the FSM continues normally.
  - flush together with wr_en in the same cycle: flush wins and the write is discarded.
  - flush in the same cycle as an IDLE pop: the pop is suppressed and the FSM stays in IDLE.
- tx_byte never changes while drain_active=1, except on the IDLE->START transition.

Decomposition:
- Shared package uart_pkg holds:
  - the BAUD_DIV (103) and HALF_BIT (51) constants used by uart_tx and uart_rx
  - the FSM state encoding localparams: IDLE=2'd0, START=2'd1, WAIT_BUSY=2'd2, WAIT_DONE=2'd3
- One natural sub-module: sync_fifo (parameterised DEPTH/AW, 8-bit data, with push, pop, flush, full, empty and level). uart_tx_fifo wraps sync_fifo together with the drain FSM.
- The bench instantiates uart_tx_fifo -> uart_tx -> uart_rx in loopback.

Test Plan:
1. Push 0x48,0x49 in consecutive cycles while idle -> tx_start pulses twice; uart_rx delivers 0x48 then 0x49 in order; level returns to 0 and empty=1.
2. Push DEPTH+1 bytes (0x00..0x10) in consecutive cycles with uart_tx busy -> full=1 after 16 accepted bytes, overflow=1. Check whether 0x10 is accepted: if a pop coincided with that write it is accepted and 17 bytes arrive; otherwise exactly 0x00..0x0F arrive.
3. Push 0xA5,0x3C,0x7E, then assert flush while 0xA5 is transmitting -> only 0xA5 is received; level=0 and overflow=0 after the flush cycle.
4. Assert rst_n=0 for 1 cycle mid-frame with 4 bytes queued -> next cycle all outputs equal their reset values; no rx_valid follows; a subsequent push of 0x55 is received correctly.
5. Push 0x00..0xFF continuously, stalling wr_en while full -> all 256 bytes are received in order; overflow stays 0; level never exceeds 16.
6. Simultaneous wr_en and pop while full (level=16) -> level stays 16, overflow stays 0, and the written byte is received last.

Source files
------------

// File: rtl/uart_tx_fifo_pkg.sv
// Shared constants and types for the buffered UART transmit path.
// Holds the baud constants used by uart_tx/uart_rx and the drain FSM encoding.
package uart_tx_fifo_pkg;

    localparam int unsigned BAUD_DIV      = 103;
    localparam int unsigned HALF_BIT      = 51;
    localparam int unsigned DATA_W        = 8;
    localparam int unsigned WAIT_BUSY_MAX = 2;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } drain_state_e;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Producer/uart_tx-facing signal bundle of uart_tx_fifo.
// master = environment side (producers + uart_tx), slave = the FIFO block.
interface uart_tx_fifo_if #(
    parameter int unsigned AW = 4
);
    import uart_tx_fifo_pkg::*;

    logic [DATA_W-1:0] wr_data;
    logic              wr_en;
    logic              flush;
    logic              full;
    logic              empty;
    logic [AW:0]       level;
    logic              overflow;
    logic [DATA_W-1:0] tx_byte;
    logic              tx_start;
    logic              tx_busy;
    logic              drain_active;

    modport master (
        output wr_data, wr_en, flush, tx_busy,
        input  full, empty, level, overflow, tx_byte, tx_start, drain_active
    );

    modport slave (
        input  wr_data, wr_en, flush, tx_busy,
        output full, empty, level, overflow, tx_byte, tx_start, drain_active
    );

endinterface

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Circular byte FIFO with registered status, sticky overflow and flush.
// A write while full is accepted only when a pop happens in the same cycle.
module uart_tx_fifo_sync_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic              i_flush,
    input  logic [DATA_W-1:0] i_wr_data,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_full,
    output logic              o_empty,
    output logic              o_overflow,
    output logic [AW:0]       o_level
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wptr;
    logic [AW-1:0]     r_rptr;
    logic [AW:0]       r_level;
    logic              r_full;
    logic              r_empty;
    logic              r_overflow;

    logic              w_pop;
    logic              w_push;
    logic [AW:0]       w_level_nxt;

    // flush dominates both ports; a pop frees the slot a full-FIFO write needs
    assign w_pop  = i_pop && !r_empty && !i_flush;
    assign w_push = i_push && !i_flush && (!r_full || w_pop);

    always_comb begin
        w_level_nxt = r_level;
        if (i_flush) begin
            w_level_nxt = '0;
        end else if (w_push && !w_pop) begin
            w_level_nxt = r_level + (AW+1)'(1);
        end else if (w_pop && !w_push) begin
            w_level_nxt = r_level - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_level    <= '0;
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (i_flush) begin
                r_rptr <= r_wptr;
            end else if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            r_level <= w_level_nxt;
            r_full  <= (w_level_nxt == (AW+1)'(DEPTH));
            r_empty <= (w_level_nxt == '0);
            if (i_flush) begin
                r_overflow <= 1'b0;
            end else if (i_push && r_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // storage needs no reset; only slots behind a valid pointer are ever read
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_wr_data;
        end
    end

    assign o_rd_data  = r_mem[r_rptr];
    assign o_full     = r_full;
    assign o_empty    = r_empty;
    assign o_overflow = r_overflow;
    assign o_level    = r_level;

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered transmit front-end: byte FIFO plus a drain FSM that feeds uart_tx
// one byte at a time through its tx_byte/tx_start/tx_busy handshake.
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    uart_tx_fifo_if.slave  bus
);

    drain_state_e      r_state;
    logic [DATA_W-1:0] r_tx_byte;
    logic              r_tx_start;
    logic              r_drain_active;
    logic              r_wait_cnt;

    logic [DATA_W-1:0] w_rd_data;
    logic              w_full;
    logic              w_empty;
    logic              w_overflow;
    logic [AW:0]       w_level;
    logic              w_pop;

    // a flush in the pop cycle suppresses the pop and keeps the FSM idle
    assign w_pop = (r_state == IDLE) && !w_empty && !bus.flush;

    uart_tx_fifo_sync_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_push     (bus.wr_en),
        .i_pop      (w_pop),
        .i_flush    (bus.flush),
        .i_wr_data  (bus.wr_data),
        .o_rd_data  (w_rd_data),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_overflow (w_overflow),
        .o_level    (w_level)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_tx_byte      <= '0;
            r_tx_start     <= 1'b0;
            r_drain_active <= 1'b0;
            r_wait_cnt     <= 1'b0;
        end else begin
            r_tx_start <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_pop) begin
                        r_tx_byte      <= w_rd_data;
                        r_tx_start     <= 1'b1;
                        r_drain_active <= 1'b1;
                        r_state        <= START;
                    end
                end
                START: begin
                    r_wait_cnt <= 1'b0;
                    r_state    <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    // give up on a busy edge that never arrives
                    if (bus.tx_busy || (r_wait_cnt == 1'(WAIT_BUSY_MAX - 1))) begin
                        r_state <= WAIT_DONE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (!bus.tx_busy) begin
                        r_drain_active <= 1'b0;
                        r_state        <= IDLE;
                    end
                end
                default: begin
                    r_drain_active <= 1'b0;
                    r_state        <= IDLE;
                end
            endcase
        end
    end

    assign bus.tx_byte      = r_tx_byte;
    assign bus.tx_start     = r_tx_start;
    assign bus.drain_active = r_drain_active;
    assign bus.full         = w_full;
    assign bus.empty        = w_empty;
    assign bus.overflow     = w_overflow;
    assign bus.level        = w_level;

endmodule
